gen_gamma_encoder: RTL and testbench

Serialising generalised Elias-gamma encoder; the transmit-side counterpart of the gen_gamma decoder. Accepts a WIDTH-bit word over a valid/ready handshake and encodes V = inp_data + 1, so zero is encodable. Emits the codeword MSB-first, one bit per handshake: L zeros, then the L+1 bits of V, where L = floor(log2 V). Sits between the data source and the serial link feeding the decoder.

---
 rtl/gen_gamma_encoder.sv | 195 +++++++++++++++++++
 tb/tb_gen_gamma_encoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/gen_gamma_encoder.sv
// gen_gamma_encoder: serialising generalised Elias-gamma encoder.
// Encodes V = inp_data + 1 as L zeros followed by the L+1 bits of V
// (MSB first), where L = floor(log2 V). One code bit per out handshake.
// Optional feature macro: GEN_GAMMA_ENC_LEN_EN adds the code_len output
// (2L+1, loaded on input acceptance).
module gen_gamma_encoder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic [WIDTH-1:0] inp_data,
  input  logic             inp_valid,
  output logic             inp_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
`ifdef GEN_GAMMA_ENC_LEN_EN
  ,
  output logic [$clog2(2*WIDTH+2)-1:0] code_len
`endif
);

  localparam int VW = WIDTH + 1;
  localparam int LW = $clog2(WIDTH + 1);

  localparam logic [LW-1:0] ZERO_L = {LW{1'b0}};
  localparam logic [LW-1:0] ONE_L  = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [VW-1:0] ONE_V  = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PREFIX = 2'd1,
    S_BODY   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [VW-1:0] v_q, v_d;
  logic [LW-1:0] l_q, l_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          out_bit_q, out_bit_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          accept;

  // Index of the highest set bit; V is never zero, so the result is L.
  function automatic logic [LW-1:0] msb_index(input logic [VW-1:0] v);
    logic [LW-1:0] idx;
    idx = ZERO_L;
    for (int i = 0; i < VW; i++) begin
      if (v[i]) begin
        idx = LW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Ready only in IDLE and never while reset is being applied.
  assign inp_ready = (state_q == S_IDLE) && !res_n;
  assign accept    = (state_q == S_IDLE) && inp_valid;

  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

  // State register plus registered copies of the serial outputs.
  always_ff @(posedge clk) begin
    if (res_n) begin
      state_q     <= S_IDLE;
      v_q         <= {VW{1'b0}};
      l_q         <= ZERO_L;
      cnt_q       <= ZERO_L;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      l_q         <= l_d;
      cnt_q       <= cnt_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Next-state logic: latch the word, walk the prefix zeros, then V's bits.
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    l_d     = l_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (inp_valid) begin
          v_d = {1'b0, inp_data} + ONE_V;
          l_d = msb_index(v_d);
          if (l_d != ZERO_L) begin
            cnt_d   = l_d - ONE_L;
            state_d = S_PREFIX;
          end else begin
            cnt_d   = ZERO_L;
            state_d = S_BODY;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREFIX: begin
        if (out_ready) begin
          if (cnt_q == ZERO_L) begin
            cnt_d   = l_q;
            state_d = S_BODY;
          end else begin
            cnt_d = cnt_q - ONE_L;
          end
        end else begin
          state_d = S_PREFIX;
        end
      end
      S_BODY: begin
        if (out_ready) begin
          if (cnt_q == ZERO_L) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - ONE_L;
          end
        end else begin
          state_d = S_BODY;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = ZERO_L;
      end
    endcase
  end

  // Output decode from the next state, so the registered outputs line up
  // with the state they describe (no path from inp_* straight to out_*).
  always_comb begin
    out_valid_d = 1'b0;
    out_bit_d   = 1'b0;
    out_last_d  = 1'b0;
    case (state_d)
      S_IDLE: begin
        out_valid_d = 1'b0;
      end
      S_PREFIX: begin
        out_valid_d = 1'b1;
      end
      S_BODY: begin
        out_valid_d = 1'b1;
        out_bit_d   = v_d[cnt_d];
        out_last_d  = (cnt_d == ZERO_L);
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

`ifdef GEN_GAMMA_ENC_LEN_EN
  localparam int CLW = $clog2(2*WIDTH+2);

  logic [CLW-1:0] code_len_q, code_len_d;

  assign code_len = code_len_q;

  // Codeword length 2L+1 captured when a word is accepted.
  always_comb begin
    if (accept) begin
      code_len_d = CLW'({l_d, 1'b1});
    end else begin
      code_len_d = code_len_q;
    end
  end

  // Code length register.
  always_ff @(posedge clk) begin
    if (res_n) begin
      code_len_q <= {CLW{1'b0}};
    end else begin
      code_len_q <= code_len_d;
    end
  end
`else
  // accept only feeds the optional length register.
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_gen_gamma_encoder.sv
// Self-checking bench for gen_gamma_encoder: directed scenarios plus random
// traffic, checked every cycle against a queue-based model of the codeword.
module tb_gen_gamma_encoder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             res_n;
  logic [WIDTH-1:0] inp_data;
  logic             inp_valid;
  logic             inp_ready;
  logic             out_bit;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
`ifdef GEN_GAMMA_ENC_LEN_EN
  logic [$clog2(2*WIDTH+2)-1:0] code_len;
  int               clen_exp = 0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Expected code bits still to be delivered: {bit, last}.
  logic [1:0] exp_q[$];

  gen_gamma_encoder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .res_n     (res_n),
    .inp_data  (inp_data),
    .inp_valid (inp_valid),
    .inp_ready (inp_ready),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
`ifdef GEN_GAMMA_ENC_LEN_EN
    ,
    .code_len  (code_len)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference: gamma code of d+1 built from integer arithmetic.
  task automatic push_word(input int d);
    int v;
    int l;
    v = d + 1;
    l = 0;
    while ((v >> (l + 1)) != 0) l++;
    for (int i = 0; i < l; i++) exp_q.push_back(2'b00);
    for (int i = l; i >= 0; i--) exp_q.push_back({((v >> i) & 1) == 1, i == 0});
`ifdef GEN_GAMMA_ENC_LEN_EN
    clen_exp = 2 * l + 1;
`endif
  endtask

  // One clock: drive inputs after the falling edge, check, then advance model.
  task automatic step(input logic iv, input logic [WIDTH-1:0] d, input logic ordy, input logic rst);
    logic exp_v;
    logic exp_rdy;
    @(negedge clk);
    inp_valid = iv;
    inp_data  = d;
    out_ready = ordy;
    res_n     = rst;
    #1;
    exp_v   = (exp_q.size() != 0);
    exp_rdy = !rst && !exp_v;
    chk("inp_ready", {31'd0, inp_ready}, {31'd0, exp_rdy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
    if (exp_v) begin
      chk("out_bit", {31'd0, out_bit}, {31'd0, exp_q[0][1]});
      chk("out_last", {31'd0, out_last}, {31'd0, exp_q[0][0]});
    end
`ifdef GEN_GAMMA_ENC_LEN_EN
    chk("code_len", {27'd0, code_len}, clen_exp);
`endif
    if (rst) begin
      exp_q.delete();
`ifdef GEN_GAMMA_ENC_LEN_EN
      clen_exp = 0;
`endif
    end else if (exp_v && ordy) begin
      void'(exp_q.pop_front());
    end else if (exp_rdy && iv) begin
      push_word(int'(d));
    end
  endtask

  // Run until the model has no bits left (bounded).
  task automatic drain(input bit random_ready);
    int budget;
    budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      step(1'b0, WIDTH'($urandom), random_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
      budget--;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    logic [WIDTH-1:0] words[3];
    logic             pat[6];
    int               k;

    res_n     = 1'b1;
    inp_valid = 1'b0;
    inp_data  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state: not ready during reset, ready with idle outputs after.
    step(1'b0, 8'd0, 1'b1, 1'b1);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("rst_out_bit", {31'd0, out_bit}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);

    // Zero input -> single '1'.
    step(1'b1, 8'd0, 1'b1, 1'b0);
    drain(1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);

    // Small value and maximum value.
    step(1'b1, 8'd4, 1'b1, 1'b0);
    drain(1'b0);
    step(1'b1, 8'd255, 1'b1, 1'b0);
    drain(1'b0);

    // Backpressure with a fixed out_ready pattern.
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    step(1'b1, 8'd2, 1'b1, 1'b0);
    foreach (pat[i]) step(1'b0, WIDTH'($urandom), pat[i], 1'b0);
    chk("bp_done", exp_q.size(), 0);
    step(1'b0, 8'd0, 1'b1, 1'b0);

    // Back-to-back with inp_valid held high and data churning mid-word.
    words = '{8'd0, 8'd1, 8'd6};
    k = 0;
    for (int c = 0; c < 20 && k <= 3; c++) begin
      if (exp_q.size() == 0) begin
        if (k < 3) step(1'b1, words[k], 1'b1, 1'b0);
        else       step(1'b0, 8'd0, 1'b1, 1'b0);
        k++;
      end else begin
        step(1'b1, WIDTH'($urandom), 1'b1, 1'b0);
      end
    end
    chk("b2b_done", exp_q.size(), 0);

    // Reset in the middle of the prefix, then a zero word.
    step(1'b1, 8'd100, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b1);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    step(1'b1, 8'd0, 1'b1, 1'b0);
    drain(1'b0);

    // Random traffic with random backpressure and occasional resets.
    for (int c = 0; c < 600; c++) begin
      logic [WIDTH-1:0] d;
      case ($urandom_range(0, 3))
        0:       d = 8'd0;
        1:       d = 8'd255;
        default: d = WIDTH'($urandom);
      endcase
      step(1'($urandom_range(0, 9) < 7), d, 1'($urandom_range(0, 9) < 6),
           1'($urandom_range(0, 99) == 0));
    end
    drain(1'b1);
    step(1'b0, 8'd0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
